// File: rtl/awgn_pkg.sv
// Shared definitions for the AWGN channel: SNR limits, sigma code table,
// 9-to-8 bit saturation and the SNR-change FSM state encoding.
package awgn_pkg;

    localparam int SNR_MIN = 7;
    localparam int SNR_MAX = 12;

    // Sigma codes, S(8,7), one per supported SNR in dB
    localparam logic [7:0] SIGMA_7DB  = 8'h1C;
    localparam logic [7:0] SIGMA_8DB  = 8'h19;
    localparam logic [7:0] SIGMA_9DB  = 8'h16;
    localparam logic [7:0] SIGMA_10DB = 8'h14;
    localparam logic [7:0] SIGMA_11DB = 8'h12;
    localparam logic [7:0] SIGMA_12DB = 8'h10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        APPLY   = 2'd2
    } snr_state_t;

    // Saturate a sign-extended 9-bit sum back to S(8,7)
    function automatic logic [7:0] sat9to8(input logic [8:0] sum);
        if (sum[8] != sum[7]) begin
            return sum[8] ? 8'h80 : 8'h7F;
        end
        return sum[7:0];
    endfunction

    // Clamp the requested SNR to the table range and look up its sigma code
    function automatic logic [7:0] snr_to_sigma(input logic [3:0] snr_db);
        logic [3:0] snr_c;
        if (snr_db < 4'(SNR_MIN)) begin
            snr_c = 4'(SNR_MIN);
        end else if (snr_db > 4'(SNR_MAX)) begin
            snr_c = 4'(SNR_MAX);
        end else begin
            snr_c = snr_db;
        end
        case (snr_c)
            4'd7:    return SIGMA_7DB;
            4'd8:    return SIGMA_8DB;
            4'd9:    return SIGMA_9DB;
            4'd10:   return SIGMA_10DB;
            4'd11:   return SIGMA_11DB;
            default: return SIGMA_12DB;
        endcase
    endfunction

endpackage

// File: rtl/awgn_channel_noise_pow_meter.sv
// Noise power meter: accumulates nI^2 + nQ^2 over windows of 2^LOG2_POW_WIN
// samples and publishes the window mean, U(16,14), with a one-cycle strobe.
// Only elaborated when AWGN_NOISE_POW_EN is defined.
`ifdef AWGN_NOISE_POW_EN
module noise_pow_meter #(
    parameter int LOG2_POW_WIN = 10
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic [7:0]  i_noise_I,
    input  logic [7:0]  i_noise_Q,
    output logic [15:0] o_noise_pow,
    output logic        o_pow_valid
);

    localparam int ACC_W = 17 + LOG2_POW_WIN;

    logic signed [7:0]  noise_i_s;
    logic signed [7:0]  noise_q_s;
    logic signed [15:0] sq_i;
    logic signed [15:0] sq_q;
    logic [16:0]        term;
    logic [ACC_W-1:0]   acc_reg;
    logic [ACC_W-1:0]   acc_total;
    logic [ACC_W-1:0]   mean;
    logic [15:0]        mean_sat;
    logic [LOG2_POW_WIN-1:0] win_cnt_reg;

    // Squares of S(8,7) values are non-negative U(16,14); (-1.0)^2 = 16'h4000 still fits
    assign noise_i_s = i_noise_I;
    assign noise_q_s = i_noise_Q;
    assign sq_i      = noise_i_s * noise_i_s;
    assign sq_q      = noise_q_s * noise_q_s;
    assign term      = {1'b0, sq_i} + {1'b0, sq_q};
    assign acc_total = acc_reg + ACC_W'(term);
    assign mean      = acc_total >> LOG2_POW_WIN;
    assign mean_sat  = (|mean[ACC_W-1:16]) ? 16'hFFFF : mean[15:0];

    // The window closes on its last sample (included in the mean); the next
    // window starts from an empty accumulator
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            acc_reg     <= '0;
            win_cnt_reg <= '0;
            o_noise_pow <= '0;
            o_pow_valid <= 1'b0;
        end else begin
            o_pow_valid <= 1'b0;
            if (i_valid) begin
                win_cnt_reg <= win_cnt_reg + 1'b1;
                if (&win_cnt_reg) begin
                    o_noise_pow <= mean_sat;
                    o_pow_valid <= 1'b1;
                    acc_reg     <= '0;
                end else begin
                    acc_reg     <= acc_total;
                end
            end
        end
    end

endmodule
`endif

// File: rtl/awgn_channel.sv
// AWGN channel: adds generator noise to S(8,7) I/Q symbols with saturation
// (2-cycle pipeline) and owns SNR selection, changing sigma only at frame wraps.
// Optional macro AWGN_NOISE_POW_EN adds the noise power meter.
module awgn_channel
    import awgn_pkg::*;
#(
    parameter int NBT_DATA     = 8,
    parameter int NBF_DATA     = 7,
    parameter int FRAME_LEN    = 1024,
    parameter int RESET_SNR    = 10,
    parameter int LOG2_POW_WIN = 10
) (
    input  logic                clk,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic [NBT_DATA-1:0] i_sym_I,
    input  logic [NBT_DATA-1:0] i_sym_Q,
    input  logic [NBT_DATA-1:0] i_noise_I,
    input  logic [NBT_DATA-1:0] i_noise_Q,
    input  logic                i_chan_en,
    input  logic                i_snr_load,
    input  logic [3:0]          i_snr_db,
    output logic [7:0]          o_sigma,
    output logic                o_snr_busy,
    output logic                o_valid,
    output logic [NBT_DATA-1:0] o_sym_I,
    output logic [NBT_DATA-1:0] o_sym_Q,
    output logic [15:0]         o_noise_pow,
    output logic                o_pow_valid
);

    localparam int             CNT_W       = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_LEN - 1);
    localparam logic [7:0]     SIGMA_RESET = snr_to_sigma(4'(RESET_SNR));

    // The datapath and sigma table are fixed to S(8,7); reject other settings at elaboration
    if (NBT_DATA != 8 || NBF_DATA != 7 || FRAME_LEN < 2 || RESET_SNR < SNR_MIN ||
        RESET_SNR > SNR_MAX || LOG2_POW_WIN < 1) begin : g_bad_cfg
        $error("awgn_channel: unsupported parameter set");
    end

    logic [NBT_DATA-1:0] noise_i_eff;
    logic [NBT_DATA-1:0] noise_q_eff;
    logic [NBT_DATA:0]   sum_i_reg;
    logic [NBT_DATA:0]   sum_q_reg;
    logic                valid1_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                wrap;
    logic [7:0]          load_code;
    snr_state_t          state_reg, state_next;
    logic [7:0]          code_reg, code_next;
    logic [7:0]          sigma_reg, sigma_next;

    // Bypass zeroes the noise so the symbol passes with unchanged latency
    assign noise_i_eff = i_chan_en ? i_noise_I : '0;
    assign noise_q_eff = i_chan_en ? i_noise_Q : '0;

    // Stage 1: sign-extended 9-bit sums; data holds during bubbles
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            valid1_reg <= 1'b0;
            sum_i_reg  <= '0;
            sum_q_reg  <= '0;
        end else begin
            valid1_reg <= i_valid;
            if (i_valid) begin
                sum_i_reg <= {i_sym_I[NBT_DATA-1], i_sym_I} + {noise_i_eff[NBT_DATA-1], noise_i_eff};
                sum_q_reg <= {i_sym_Q[NBT_DATA-1], i_sym_Q} + {noise_q_eff[NBT_DATA-1], noise_q_eff};
            end
        end
    end

    // Stage 2: saturate back to S(8,7)
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_sym_I <= '0;
            o_sym_Q <= '0;
        end else begin
            o_valid <= valid1_reg;
            if (valid1_reg) begin
                o_sym_I <= sat9to8(sum_i_reg);
                o_sym_Q <= sat9to8(sum_q_reg);
            end
        end
    end

    assign wrap      = i_valid && (cnt_reg == CNT_LAST);
    assign load_code = snr_to_sigma(i_snr_db);

    // Frame counter over accepted samples
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_reg <= '0;
        end else if (i_valid) begin
            cnt_reg <= wrap ? '0 : cnt_reg + 1'b1;
        end
    end

    // SNR FSM state, latched request code and the live sigma register
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg <= IDLE;
            code_reg  <= SIGMA_RESET;
            sigma_reg <= SIGMA_RESET;
        end else begin
            state_reg <= state_next;
            code_reg  <= code_next;
            sigma_reg <= sigma_next;
        end
    end

    // Next state: sigma is loaded on the wrap edge itself so the new code is
    // visible in APPLY, the cycle after the wrap; a wrap seen in IDLE is ignored
    always_comb begin
        state_next = state_reg;
        code_next  = code_reg;
        sigma_next = sigma_reg;
        case (state_reg)
            IDLE: begin
                if (i_snr_load) begin
                    code_next  = load_code;
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (wrap) begin
                    // a request on the wrap cycle itself is the latest one and wins
                    sigma_next = i_snr_load ? load_code : code_reg;
                    code_next  = sigma_next;
                    state_next = APPLY;
                end else if (i_snr_load) begin
                    code_next = load_code;
                end
            end
            APPLY: begin
                if (i_snr_load) begin
                    code_next  = load_code;
                    state_next = PENDING;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign o_sigma    = sigma_reg;
    assign o_snr_busy = (state_reg == PENDING);

`ifdef AWGN_NOISE_POW_EN
    // Measures the noise actually added, so bypass reads as zero power
    noise_pow_meter #(
        .LOG2_POW_WIN (LOG2_POW_WIN)
    ) u_noise_pow_meter (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .i_noise_I   (noise_i_eff),
        .i_noise_Q   (noise_q_eff),
        .o_noise_pow (o_noise_pow),
        .o_pow_valid (o_pow_valid)
    );
`else
    assign o_noise_pow = '0;
    assign o_pow_valid = 1'b0;
`endif

endmodule
